// File: rtl/option_queue.sv
// Circular token store between the parser (load side) and the solver's option FIFO handshake.
// The parser fills it once; the solver then pops the head and pushes survivors back.
module option_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             started,
  input  logic             read_from_fifo,
  output logic [WIDTH-1:0] option,
  input  logic             put_back_to_FIFO,
  input  logic [WIDTH-1:0] new_option,
  input  logic             clear,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  typedef enum logic [1:0] {StLoad, StDone, StRun} state_e;

  // DEPTH is a power of two, so a full queue has only the top count bit set.
  localparam logic [AW:0] FullCount = {1'b1, {AW{1'b0}}};

  state_e           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             load_ready_q, load_ready_d;
  logic             started_q, started_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCount);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    wdata       = new_option;

    if (clear) begin
      state_d     = StLoad;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (load_valid && load_ready_q) begin
            we       = 1'b1;
            wdata    = load_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            if (load_last) state_d = StDone;
          end
        end
        StDone: state_d = StRun;
        StRun: begin
          if (read_from_fifo && put_back_to_FIFO) begin
            // The push always lands; on an empty queue the pop has nothing to take.
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (is_empty) begin
              count_d     = count_q + 1'b1;
              underflow_d = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end else if (put_back_to_FIFO) begin
            if (is_full) begin
              overflow_d = 1'b1;
            end else begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              count_d  = count_q + 1'b1;
            end
          end else if (read_from_fifo) begin
            if (is_empty) begin
              underflow_d = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
              count_d  = count_q - 1'b1;
            end
          end
        end
        default: state_d = StLoad;
      endcase
    end

    started_d    = (state_q == StDone) && !clear;
    load_ready_d = (state_d == StLoad) && (count_d != FullCount);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StLoad;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      load_ready_q <= 1'b0;
      started_q    <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      load_ready_q <= load_ready_d;
      started_q    <= started_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is deliberately not reset or cleared; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= wdata;
  end

  assign option     = is_empty ? '0 : mem_q[rd_ptr_q];
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign load_ready = load_ready_q;
  assign started    = started_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_option_queue.sv
// Bench for option_queue: a 1024-deep and an 8-deep instance share one stimulus stream and are
// each checked every cycle against a queue-based model, plus directed literal expectations.
module tb_option_queue;

  localparam int unsigned D0 = 1024;
  localparam int unsigned D1 = 8;
  localparam int PhLoad = 0;
  localparam int PhDone = 1;
  localparam int PhRun  = 2;

  typedef logic [15:0] tokq_t [$];

  logic        clk;
  logic        rst;
  logic        lv, ll, rf, pb, clr;
  logic [15:0] ld, nw;

  logic        load_ready0, started0, empty0, full0, overflow0, underflow0;
  logic [15:0] option0;
  logic [10:0] count0;
  logic        load_ready1, started1, empty1, full1, overflow1, underflow1;
  logic [15:0] option1;
  logic [3:0]  count1;

  option_queue #(.WIDTH(16), .DEPTH(D0)) u_q0 (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_last(ll),
    .load_ready(load_ready0), .started(started0), .read_from_fifo(rf), .option(option0),
    .put_back_to_FIFO(pb), .new_option(nw), .clear(clr), .count(count0), .empty(empty0),
    .full(full0), .overflow(overflow0), .underflow(underflow0)
  );

  option_queue #(.WIDTH(16), .DEPTH(D1)) u_q1 (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_last(ll),
    .load_ready(load_ready1), .started(started1), .read_from_fifo(rf), .option(option1),
    .put_back_to_FIFO(pb), .new_option(nw), .clear(clr), .count(count1), .empty(empty1),
    .full(full1), .overflow(overflow1), .underflow(underflow1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  tokq_t mq0, mq1;
  int    mph    [2];
  bit    mrdy   [2];
  bit    mstart [2];
  bit    movf   [2];
  bit    munf   [2];

  task automatic mreset();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      mph[k] = PhLoad; mrdy[k] = 1'b0; mstart[k] = 1'b0; movf[k] = 1'b0; munf[k] = 1'b0;
    end
  endtask

  task automatic mstep(input int k, input int unsigned d, inout tokq_t q);
    int ph;
    ph = mph[k];
    if (clr) begin
      q.delete();
      mph[k] = PhLoad; movf[k] = 1'b0; munf[k] = 1'b0;
    end else if (ph == PhLoad) begin
      if (lv && mrdy[k]) begin
        q.push_back(ld);
        if (ll) mph[k] = PhDone;
      end
    end else if (ph == PhDone) begin
      mph[k] = PhRun;
    end else if (rf && pb) begin
      if (q.size() == 0) munf[k] = 1'b1;
      else q.delete(0);
      q.push_back(nw);
    end else if (pb) begin
      if (q.size() == int'(d)) movf[k] = 1'b1;
      else q.push_back(nw);
    end else if (rf) begin
      if (q.size() == 0) munf[k] = 1'b1;
      else q.delete(0);
    end
    mstart[k] = (ph == PhDone) && !clr;
    mrdy[k]   = (mph[k] == PhLoad) && (q.size() != int'(d));
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) mreset();
      else begin
        mstep(0, D0, mq0);
        mstep(1, D1, mq1);
      end
    end
  end

  task automatic cmp(input string tag, input int k, input int unsigned d, input tokq_t q,
                     input logic [31:0] cnt, input logic emp, input logic ful,
                     input logic [15:0] opt, input logic lr, input logic st,
                     input logic ov, input logic un);
    logic [15:0] eopt;
    eopt = (q.size() != 0) ? q[0] : 16'h0;
    check({tag, "_count"}, cnt, 32'(q.size()));
    check({tag, "_empty"}, 32'(emp), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(ful), 32'(q.size() == int'(d)));
    check({tag, "_option"}, 32'(opt), 32'(eopt));
    check({tag, "_load_ready"}, 32'(lr), 32'(mrdy[k]));
    check({tag, "_started"}, 32'(st), 32'(mstart[k]));
    check({tag, "_overflow"}, 32'(ov), 32'(movf[k]));
    check({tag, "_underflow"}, 32'(un), 32'(munf[k]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("q1024", 0, D0, mq0, 32'(count0), empty0, full0, option0, load_ready0, started0,
            overflow0, underflow0);
        cmp("q8", 1, D1, mq1, 32'(count1), empty1, full1, option1, load_ready1, started1,
            overflow1, underflow1);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lv = 1'b0; ll = 1'b0; ld = '0; rf = 1'b0; pb = 1'b0; nw = '0; clr = 1'b0;
  endtask

  logic [15:0] tok4 [4];

  initial begin
    tok4[0] = 16'h0003; tok4[1] = 16'h0005; tok4[2] = 16'h0006; tok4[3] = 16'h000C;
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_count", 32'(count0), 0);
    check("reset_empty", 32'(empty0), 1);
    check("reset_load_ready", 32'(load_ready0), 0);
    rst = 1'b1;
    cyc();
    check("ready_after_reset", 32'(load_ready0), 1);

    // Four-token load, then started two cycles after the last accept.
    for (int i = 0; i < 4; i++) begin
      check("load_ready_during_load", 32'(load_ready0), 1);
      lv = 1'b1; ld = tok4[i]; ll = (i == 3);
      cyc();
    end
    idle();
    check("no_started_in_done", 32'(started0), 0);
    cyc();
    check("started_pulse", 32'(started0), 1);
    check("count_after_load", 32'(count0), 4);
    check("head_after_load", 32'(option0), 32'h3);
    cyc();
    check("started_one_cycle", 32'(started0), 0);

    // Circulate: pop with echo put-back.
    for (int i = 0; i < 5; i++) begin
      check("echo_option", 32'(option0), 32'(tok4[i % 4]));
      check("echo_count", 32'(count0), 4);
      if (i < 4) begin
        rf = 1'b1; pb = 1'b1; nw = tok4[i];
        cyc();
      end
    end
    idle();

    // Fill to DEPTH, dropped push, then pop+push at full and drain.
    clr = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 1024; i++) begin
      lv = 1'b1; ld = 16'(i); ll = (i == 1023);
      cyc();
    end
    idle();
    cyc();
    cyc();
    check("full_after_load", 32'(full0), 1);
    check("count_full", 32'(count0), 1024);
    pb = 1'b1; nw = 16'hBEEF;
    cyc();
    idle();
    check("overflow_set", 32'(overflow0), 1);
    check("count_after_drop", 32'(count0), 1024);
    check("head_after_drop", 32'(option0), 0);
    rf = 1'b1; pb = 1'b1; nw = 16'hBEEF;
    cyc();
    idle();
    check("count_pop_push_full", 32'(count0), 1024);
    check("full_pop_push", 32'(full0), 1);
    for (int i = 1; i < 1024; i++) begin
      check("drain_order", 32'(option0), 32'(i));
      rf = 1'b1;
      cyc();
    end
    idle();
    check("beef_last", 32'(option0), 32'hBEEF);
    check("count_before_last_pop", 32'(count0), 1);
    rf = 1'b1;
    cyc();
    idle();
    check("empty_after_drain", 32'(empty0), 1);

    // Empty RUN queue: lone pop, then pop+push.
    rf = 1'b1;
    cyc();
    idle();
    check("underflow_set", 32'(underflow0), 1);
    check("count_after_underflow", 32'(count0), 0);
    check("option_when_empty", 32'(option0), 0);
    rf = 1'b1; pb = 1'b1; nw = 16'h0011;
    cyc();
    idle();
    check("count_pop_push_empty", 32'(count0), 1);
    check("option_pop_push_empty", 32'(option0), 32'h11);

    // Clear mid-RUN with push and pop also asserted.
    check("overflow_before_clear", 32'(overflow0), 1);
    clr = 1'b1; rf = 1'b1; pb = 1'b1; nw = 16'h0022;
    cyc();
    idle();
    check("clear_count", 32'(count0), 0);
    check("clear_empty", 32'(empty0), 1);
    check("clear_overflow", 32'(overflow0), 0);
    check("clear_underflow", 32'(underflow0), 0);
    check("clear_load_ready", 32'(load_ready0), 1);

    // Wrap on the 8-deep ring: 5 tokens, 20 pop/push pairs.
    for (int i = 0; i < 5; i++) begin
      lv = 1'b1; ld = 16'(16'hA0 + i); ll = (i == 4);
      cyc();
    end
    idle();
    cyc();
    cyc();
    check("wrap_count_start", 32'(count1), 5);
    for (int j = 0; j < 20; j++) begin
      check("wrap_order", 32'(option1), 32'(16'hA0 + j % 5));
      rf = 1'b1; pb = 1'b1; nw = 16'(16'hA0 + j % 5);
      cyc();
    end
    idle();
    check("wrap_count_end", 32'(count1), 5);
    check("wrap_head_end", 32'(option1), 32'hA0);

    // Asynchronous reset in the middle of a load.
    clr = 1'b1;
    cyc();
    idle();
    lv = 1'b1; ld = 16'h0077;
    cyc();
    cyc();
    check("count_mid_load", 32'(count0), 2);
    #2 rst = 1'b0;
    #1;
    check("async_count", 32'(count0), 0);
    check("async_empty", 32'(empty0), 1);
    check("async_full", 32'(full0), 0);
    check("async_load_ready", 32'(load_ready0), 0);
    check("async_started", 32'(started0), 0);
    check("async_option", 32'(option0), 0);
    check("async_flags", 32'({overflow0, underflow0}), 0);
    idle();
    cyc();
    rst = 1'b1;
    cyc();
    check("ready_after_rerelease", 32'(load_ready0), 1);
    cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
